// File: rtl/sms4_pkg.sv
//==============================================================================
// Module      : sms4_pkg
// Description : Shared definitions for the SM4 tau scheduler: FSM state
//               encoding, requester ID constants and the per-word byte count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sms4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic ID_ENC = 1'b0;
  localparam logic ID_KEY = 1'b1;

  localparam int         BYTE_COUNT = 4;
  localparam logic [1:0] LAST_BYTE  = 2'(BYTE_COUNT - 1);

endpackage

`default_nettype wire

// File: rtl/sbox_core.sv
//==============================================================================
// Module      : sbox_core
// Description : Combinational SM4 8-bit S-box built on composite-field
//               inversion.  S(x) = A * inv(A*x ^ C) ^ C over GF(2^8) mod 0x1F5.
//               The input affine step is fused with the isomorphic map into
//               GF((2^4)^2); the inverse map is fused with the output affine.
// Ports       : din  - input byte
//               dout - substituted byte
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sbox_core (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [8:0] FIELD_POLY   = 9'h1F5;  // SM4 polynomial basis field
  localparam logic [7:0] AFFINE_ROW   = 8'hA7;   // output bit i = parity(x & rotl(row, i))
  localparam logic [7:0] AFFINE_CONST = 8'hD3;

  // GF(2^4) multiply, modulus x^4 + x + 1.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // a^14 == a^-1 in GF(2^4); maps 0 to 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    return gf16_mul(gf16_mul(a8, a4), a2);
  endfunction

  // Composite element {hi, lo} = hi*y + lo with y^2 = y + lambda.
  function automatic logic [7:0] comp_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] lam);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, lam) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  // Inverse via the norm: d = h^2*lambda + h*l + l^2, inv = (h*y + h + l) / d.
  function automatic logic [7:0] comp_inv(input logic [7:0] a, input logic [3:0] lam);
    logic [3:0] d, di;
    d  = gf16_mul(gf16_mul(a[7:4], a[7:4]), lam) ^ gf16_mul(a[7:4], a[3:0]) ^
         gf16_mul(a[3:0], a[3:0]);
    di = gf16_inv(d);
    return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
  endfunction

  // Smallest lambda for which y^2 + y + lambda has no root in GF(2^4).
  function automatic logic [3:0] find_lambda(input logic [3:0] start);
    logic [3:0] lam;
    logic       found, has_root;
    lam   = '0;
    found = 1'b0;
    for (int l = 1; l < 16; l++) begin
      has_root = 1'b0;
      for (int g = 0; g < 16; g++) begin
        if ((gf16_mul(4'(g), 4'(g)) ^ 4'(g)) == 4'(l)) has_root = 1'b1;
      end
      if (!found && !has_root && 4'(l) >= start) begin
        lam   = 4'(l);
        found = 1'b1;
      end
    end
    return lam;
  endfunction

  // A composite-field root of FIELD_POLY fixes the isomorphism x^i -> r^i.
  function automatic logic [7:0] find_root(input logic [3:0] lam);
    logic [7:0] root, pw, acc;
    logic       found;
    root  = '0;
    found = 1'b0;
    for (int c = 1; c < 256; c++) begin
      acc = '0;
      pw  = 8'h01;
      for (int k = 0; k < 9; k++) begin
        if (FIELD_POLY[k]) acc = acc ^ pw;
        pw = comp_mul(pw, 8'(c), lam);
      end
      if (!found && acc == 8'h00) begin
        root  = 8'(c);
        found = 1'b1;
      end
    end
    return root;
  endfunction

  // Linear map given as eight packed columns: column i is the image of bit i.
  function automatic logic [7:0] apply_cols(input logic [63:0] cols, input logic [7:0] x);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) acc = acc ^ cols[8*i +: 8];
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine_lin(input logic [7:0] x);
    logic [7:0] rot;
    logic [7:0] y;
    rot = AFFINE_ROW;
    y   = '0;
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(x & rot);
      rot  = {rot[6:0], rot[7]};
    end
    return y;
  endfunction

  function automatic logic [63:0] build_iso(input logic [7:0] root, input logic [3:0] lam);
    logic [63:0] cols;
    logic [7:0]  pw;
    pw = 8'h01;
    cols = '0;
    for (int i = 0; i < 8; i++) begin
      cols[8*i +: 8] = pw;
      pw = comp_mul(pw, root, lam);
    end
    return cols;
  endfunction

  function automatic logic [63:0] build_inv(input logic [63:0] iso);
    logic [63:0] cols;
    cols = '0;
    for (int j = 0; j < 8; j++) begin
      for (int b = 1; b < 256; b++) begin
        if (apply_cols(iso, 8'(b)) == (8'h01 << j)) cols[8*j +: 8] = 8'(b);
      end
    end
    return cols;
  endfunction

  function automatic logic [63:0] build_in(input logic [63:0] iso);
    logic [63:0] cols;
    cols = '0;
    for (int i = 0; i < 8; i++) begin
      cols[8*i +: 8] = apply_cols(iso, affine_lin(8'h01 << i));
    end
    return cols;
  endfunction

  function automatic logic [63:0] build_out(input logic [63:0] inv);
    logic [63:0] cols;
    cols = '0;
    for (int i = 0; i < 8; i++) begin
      cols[8*i +: 8] = affine_lin(apply_cols(inv, 8'h01 << i));
    end
    return cols;
  endfunction

  // All mapping matrices are elaboration-time constants.
  localparam logic [3:0]  LAMBDA   = find_lambda(4'h1);
  localparam logic [7:0]  ROOT     = find_root(LAMBDA);
  localparam logic [63:0] ISO_COLS = build_iso(ROOT, LAMBDA);
  localparam logic [63:0] INV_COLS = build_inv(ISO_COLS);
  localparam logic [63:0] IN_COLS  = build_in(ISO_COLS);
  localparam logic [7:0]  IN_CONST = apply_cols(ISO_COLS, AFFINE_CONST);
  localparam logic [63:0] OUT_COLS = build_out(INV_COLS);

  logic [7:0] mapped;
  logic [7:0] inverted;

  always_comb begin
    mapped   = apply_cols(IN_COLS, din) ^ IN_CONST;
    inverted = comp_inv(mapped, LAMBDA);
    dout     = apply_cols(OUT_COLS, inverted) ^ AFFINE_CONST;
  end

endmodule

`default_nettype wire

// File: rtl/tau_sched.sv
//==============================================================================
// Module      : tau_sched
// Description : Shares one SM4 S-box between the round-function (enc) and the
//               key-expansion (key) requesters.  A granted word is substituted
//               one byte per cycle (byte 3 first) and returned with its owner.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               enc_req_valid/data/ready       - enc request handshake
//               key_req_valid/data/ready       - key request handshake
//               rsp_valid/id/data, rsp_ready   - response handshake
//               busy                           - high whenever not IDLE
// Parameters  : KEY_PRIO - 0 round-robin, 1 key has fixed priority
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tau_sched
  import sms4_pkg::*;
#(
  parameter bit KEY_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enc_req_valid,
  input  logic [31:0] enc_req_data,
  output logic        enc_req_ready,
  input  logic        key_req_valid,
  input  logic [31:0] key_req_data,
  output logic        key_req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [31:0] word;
  logic [31:0] result;
  logic        owner;
  logic        last_grant;
  logic        grant_key;
  logic        accept;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;

  // Arbitration winner, meaningful only while at least one requester is valid.
  always_comb begin
    grant_key = key_req_valid;
    if (key_req_valid && enc_req_valid) begin
      grant_key = KEY_PRIO ? 1'b1 : (last_grant == ID_ENC);
    end
  end

  always_comb begin
    state_nxt     = state;
    enc_req_ready = 1'b0;
    key_req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        enc_req_ready = enc_req_valid && !grant_key;
        key_req_ready = key_req_valid && grant_key;
        if (enc_req_valid || key_req_valid) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (cnt == 2'd0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept  = (state == ST_IDLE) && (enc_req_valid || key_req_valid);
  assign sbox_in = word[{cnt, 3'b000} +: 8];

  sbox_core u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      word       <= '0;
      result     <= '0;
      owner      <= ID_ENC;
      last_grant <= ID_KEY;  // enc wins the first tie after reset
    end else begin
      state <= state_nxt;
      if (accept) begin
        word       <= grant_key ? key_req_data : enc_req_data;
        owner      <= grant_key ? ID_KEY : ID_ENC;
        last_grant <= grant_key ? ID_KEY : ID_ENC;
        cnt        <= LAST_BYTE;
        result     <= '0;
      end else if (state == ST_LOOKUP) begin
        result[{cnt, 3'b000} +: 8] <= sbox_out;
        if (cnt != 2'd0) cnt <= cnt - 2'd1;
      end
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = rsp_valid & owner;
  assign rsp_data  = rsp_valid ? result : 32'h0;
  assign busy      = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tau_sched.sv
//==============================================================================
// Module      : tb_tau_sched
// Description : Self-checking bench for tau_sched.  One instance runs in
//               round-robin mode, a second with key priority.  Table-driven
//               enc transactions plus directed arbitration, stall and reset
//               sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tau_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance
  logic        enc_req_valid = 1'b0;
  logic [31:0] enc_req_data  = 32'h0;
  logic        key_req_valid = 1'b0;
  logic [31:0] key_req_data  = 32'h0;
  logic        rsp_ready     = 1'b0;
  logic        enc_req_ready, key_req_ready, rsp_valid, rsp_id, busy;
  logic [31:0] rsp_data;

  // key-priority instance
  logic        p_enc_valid = 1'b0;
  logic [31:0] p_enc_data  = 32'h0;
  logic        p_key_valid = 1'b0;
  logic [31:0] p_key_data  = 32'h0;
  logic        p_rsp_ready = 1'b0;
  logic        p_enc_ready, p_key_ready, p_rsp_valid, p_rsp_id, p_busy;
  logic [31:0] p_rsp_data;

  tau_sched #(.KEY_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .enc_req_valid(enc_req_valid), .enc_req_data(enc_req_data), .enc_req_ready(enc_req_ready),
    .key_req_valid(key_req_valid), .key_req_data(key_req_data), .key_req_ready(key_req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  tau_sched #(.KEY_PRIO(1'b1)) dut_kp (
    .clk(clk), .rst_n(rst_n),
    .enc_req_valid(p_enc_valid), .enc_req_data(p_enc_data), .enc_req_ready(p_enc_ready),
    .key_req_valid(p_key_valid), .key_req_data(p_key_data), .key_req_ready(p_key_ready),
    .rsp_valid(p_rsp_valid), .rsp_id(p_rsp_id), .rsp_data(p_rsp_data), .rsp_ready(p_rsp_ready),
    .busy(p_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at the negedge just after an accept edge; returns how many further
  // negedges pass before rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 12) begin
      check("readys low while busy", {enc_req_ready, key_req_ready}, 0);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic serve_enc(input logic [31:0] din, input logic [31:0] dout, input bit corrupt);
    int lat;
    @(negedge clk);
    enc_req_valid = 1'b1;
    enc_req_data  = din;
    rsp_ready     = 1'b1;
    #1 check("enc ready in idle", enc_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    enc_req_valid = 1'b0;
    enc_req_data  = corrupt ? ~din : 32'h0;
    check("busy after accept", busy, 1);
    wait_rsp(lat);
    check("enc latency", lat, 4);
    check("enc rsp_id", rsp_id, 0);
    check("enc rsp_data", rsp_data, dout);
    @(negedge clk);
    check("idle rsp_valid", rsp_valid, 0);
    check("idle rsp_data zero", rsp_data, 0);
    check("idle busy", busy, 0);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    bit          corrupt;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    int lat;
    int nk, ne, nr;
    bit seen;
    logic        exp_id[3];
    logic [31:0] exp_word[3];

    vecs[0] = '{32'h00010203, 32'hD690E9FE, 1'b0};
    vecs[1] = '{32'h04050607, 32'hCCE13DB7, 1'b1};
    vecs[2] = '{32'h08090A0B, 32'h16B614C2, 1'b0};
    vecs[3] = '{32'h0C0D0E0F, 32'h28FB2C05, 1'b1};
    vecs[4] = '{32'hF0F1F2F3, 32'h18F07DEC, 1'b0};
    vecs[5] = '{32'hFCFDFEFF, 32'hD7CB3948, 1'b1};
    vecs[6] = '{32'h00000000, 32'hD6D6D6D6, 1'b0};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_id", rsp_id, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset busy", busy, 0);
    check("reset kp busy", p_busy, 0);
    check("reset kp rsp_data", p_rsp_data, 0);
    rst_n = 1'b1;

    // ---- round-robin tie: enc, key, enc ----
    @(negedge clk);
    enc_req_valid = 1'b1; enc_req_data = 32'h00000000;
    key_req_valid = 1'b1; key_req_data = 32'hFFFFFFFF;
    rsp_ready     = 1'b1;
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
    exp_word[0] = 32'hD6D6D6D6; exp_word[1] = 32'h48484848; exp_word[2] = 32'hD6D6D6D6;
    for (int t = 0; t < 3; t++) begin
      int w;
      w = 0;
      #1;
      while (!(enc_req_ready || key_req_ready) && w < 10) begin
        @(negedge clk); #1; w++;
      end
      check("rr spacing", w, (t == 0) ? 0 : 1);
      check("rr single grant", enc_req_ready & key_req_ready, 0);
      check("rr grant owner", key_req_ready, exp_id[t]);
      @(posedge clk);
      @(negedge clk);
      wait_rsp(lat);
      check("rr latency", lat, 4);
      check("rr rsp_id", rsp_id, exp_id[t]);
      check("rr rsp_data", rsp_data, exp_word[t]);
    end
    @(negedge clk);
    enc_req_valid = 1'b0;
    key_req_valid = 1'b0;

    // ---- table of enc-only words ----
    for (int i = 0; i < 7; i++) begin
      serve_enc(vecs[i].din, vecs[i].dout, vecs[i].corrupt);
    end

    // ---- response stall with both requesters waiting ----
    @(negedge clk);
    enc_req_valid = 1'b1; enc_req_data = 32'h04050607; rsp_ready = 1'b0;
    #1 check("stall enc ready", enc_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    enc_req_data  = 32'h0C0D0E0F;
    key_req_valid = 1'b1; key_req_data = 32'hFFFFFFFF;
    wait_rsp(lat);
    check("stall latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      check("stall rsp_valid", rsp_valid, 1);
      check("stall rsp_data", rsp_data, 32'hCCE13DB7);
      check("stall readys", {enc_req_ready, key_req_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("handshake edge readys", {enc_req_ready, key_req_ready}, 0);
    @(negedge clk);
    check("post stall rsp_valid", rsp_valid, 0);
    check("post stall rsp_data", rsp_data, 0);
    check("post stall key ready", key_req_ready, 1);
    check("post stall enc ready", enc_req_ready, 0);
    // withdraw before the edge: no grant, pointer untouched
    enc_req_valid = 1'b0;
    key_req_valid = 1'b0;
    @(negedge clk);
    check("withdraw no accept", busy, 0);
    enc_req_valid = 1'b1;
    key_req_valid = 1'b1;
    #1 check("withdraw pointer kept", key_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    enc_req_valid = 1'b0;
    key_req_valid = 1'b0;
    wait_rsp(lat);
    check("key latency", lat, 4);
    check("key rsp_id", rsp_id, 1);
    check("key rsp_data", rsp_data, 32'h48484848);
    @(negedge clk);

    // ---- reset during LOOKUP byte 2 ----
    @(negedge clk);
    enc_req_valid = 1'b1; enc_req_data = 32'h08090A0B;
    @(posedge clk);
    @(negedge clk);
    enc_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort rsp_valid", rsp_valid, 0);
    check("abort rsp_id", rsp_id, 0);
    check("abort rsp_data", rsp_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("aborted word never answered", seen, 0);
    serve_enc(32'h08090A0B, 32'h16B614C2, 1'b0);

    // ---- key priority instance, both valid continuously ----
    @(negedge clk);
    p_enc_valid = 1'b1; p_enc_data = 32'h00010203;
    p_key_valid = 1'b1; p_key_data = 32'hF0F1F2F3;
    p_rsp_ready = 1'b1;
    nk = 0; ne = 0; nr = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (p_key_ready) nk++;
      if (p_enc_ready) ne++;
      if (p_rsp_valid) begin
        nr++;
        check("kp rsp_id", p_rsp_id, 1);
        check("kp rsp_data", p_rsp_data, 32'h18F07DEC);
      end
      @(negedge clk);
    end
    p_enc_valid = 1'b0;
    p_key_valid = 1'b0;
    check("kp key grants", nk, 4);
    check("kp enc grants", ne, 0);
    check("kp responses", nr, 3);

    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/tau_sched.md
TAU_SCHED -- requirements
Module: tau_sched

Interface
REQ-001 Parameter: KEY_PRIO, 0, arbitration mode: 0 = round-robin between requesters, 1 = key requester has fixed priority.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enc_req_valid  input  1  round-function requester presents a word.
REQ-006 enc_req_data  input  32  word to be tau-transformed (bytes [31:24]..[7:0]).
REQ-007 enc_req_ready  output  1  enc request accepted this cycle when high with enc_req_valid.
REQ-008 key_req_valid  input  1  key-expansion requester presents a word.
REQ-009 key_req_data  input  32  word to be tau-transformed.
REQ-010 key_req_ready  output  1  key request accepted this cycle when high with key_req_valid.
REQ-011 rsp_valid  output  1  result word available.
REQ-012 rsp_id  output  1  owner of result: 0 = enc, 1 = key.
REQ-013 rsp_data  output  32  tau(input word), S-box applied per byte.
REQ-014 rsp_ready  input  1  consumer takes result when high with rsp_valid.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL share one 8-bit S-box instance across both requesters, applying it to one byte per cycle.
REQ-017 The FSM SHALL have states IDLE, LOOKUP, RESP.
REQ-018 In IDLE, ready SHALL be asserted combinationally only to the arbitration winner among valid requesters; both readys SHALL be low in LOOKUP and RESP.
REQ-019 Round-robin (KEY_PRIO=0): with both valid, the requester not granted last SHALL win; the last-grant pointer SHALL update only on an accepted handshake.
REQ-020 KEY_PRIO=1: key SHALL win whenever key_req_valid is high in IDLE.
REQ-021 On accept edge, the word and requester ID SHALL be captured, byte counter set to 3, state -> LOOKUP; later changes on req_data SHALL be ignored.
REQ-022 In LOOKUP, each cycle the S-box output for byte[counter] SHALL be written to the same byte of the result register; counter decrements; after byte 0 state -> RESP.
REQ-023 Latency: rsp_valid SHALL rise exactly 4 cycles after the accept edge (visible in cycle 5 after accept).
REQ-024 In RESP, rsp_valid, rsp_id, rsp_data SHALL be held stable until rsp_ready is sampled high; on that edge state -> IDLE.
REQ-025 A new request SHALL not be accepted on the same edge as the response handshake; minimum spacing is 6 cycles per word.
REQ-026 rsp_data SHALL be zero outside RESP.
REQ-027 A requester dropping valid before ready SHALL cause no grant and no pointer update.

Reset
REQ-028 On rst_n low, state SHALL be IDLE, counter 0, result register 0, rsp_valid 0, rsp_id 0, busy 0, last-grant pointer = key (so enc wins the first tie).
REQ-029 Reset asserted during LOOKUP or RESP SHALL abort the operation with no response ever issued for it.
REQ-030 Reset deassertion SHALL take effect on the next rising clk; no request accepted in the deassertion cycle if rst_n was low at that edge.

Structure
REQ-031 Shared package sms4_pkg SHALL hold the FSM state encoding, requester ID constants (ID_ENC=0, ID_KEY=1) and byte-count constant (4).
REQ-032 The S-box SHALL be one sub-module, sbox_core: 8-bit combinational, isomorphic map, GF((2^4)^2) inversion, inverse map with affine output.

Verification
REQ-033 enc only, data 0x00010203, rsp_ready=1 -> rsp_valid 4 cycles after accept, rsp_id=0, rsp_data=0xD690E9FE.
REQ-034 Both valid every cycle, KEY_PRIO=0, words 0x00000000 (enc) / 0xFFFFFFFF (key) -> grants alternate enc, key, enc; results 0xD6D6D6D6 and 0x48484848 with matching rsp_id.
REQ-035 KEY_PRIO=1, both valid continuously -> key granted every time, enc_req_ready never high.
REQ-036 rsp_ready held low 10 cycles in RESP -> rsp_valid/rsp_data stable, both readys low, no new accept until cycle after handshake.
REQ-037 rst_n pulsed low during LOOKUP byte 2 -> rsp_valid never rises for that word, all outputs at reset values, next enc request served normally.
REQ-038 req_data changed in cycle after accept -> rsp_data reflects captured word only.
